// File: rtl/des_decrypt_iter.sv
// rtl/des_decrypt_iter.sv - iterative DES decryption core, one Feistel round per clock
// Optional key parity flag enabled by defining DES_DECRYPT_PARITY_CHECK_EN.
module des_decrypt_iter #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] cipherText,
  input  logic [0:63] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] decrypted
`ifdef DES_DECRYPT_PARITY_CHECK_EN
  , output logic      key_parity_err
`endif
);

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21, 29,12,28,17, 1,15,23,26, 5,18,31,10,
                              2,8,24,14, 32,27,3,9, 19,13,30,6, 22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // Row-major: entry index is row*16 + column.
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  rnd;
  logic [0:31] l, r, f;
  logic [0:55] cd, cd_rot;
  logic [0:47] subkey;

  function automatic logic [0:63] perm64(input logic [0:63] x, input logic use_fp);
    for (int i = 0; i < 64; i++)
      perm64[i] = use_fp ? x[6'(FP_T[i] - 1)] : x[6'(IP_T[i] - 1)];
  endfunction

  function automatic logic [0:55] pc1(input logic [0:63] x);
    for (int i = 0; i < 56; i++) pc1[i] = x[6'(PC1_T[i] - 1)];
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] x);
    for (int i = 0; i < 48; i++) pc2[i] = x[6'(PC2_T[i] - 1)];
  endfunction

  function automatic logic [0:47] expand(input logic [0:31] x);
    for (int i = 0; i < 48; i++) expand[i] = x[5'(E_T[i] - 1)];
  endfunction

  function automatic logic [0:31] pperm(input logic [0:31] x);
    for (int i = 0; i < 32; i++) pperm[i] = x[5'(P_T[i] - 1)];
  endfunction

  // Six input bits per box; row = {b0,b5}, column = b1..b4.
  function automatic logic [0:31] sbox_layer(input logic [0:47] x);
    logic [0:5] b;
    for (int j = 0; j < 8; j++) begin
      b = x[6*j +: 6];
      sbox_layer[4*j +: 4] = 4'(SBOX[j][{b[0], b[5], b[1:4]}]);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ROUND;
      end
      ROUND: if (rnd == 5'(ROUNDS)) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Decryption walks the key schedule backwards, so halves rotate right.
  always_comb begin
    cd_rot = cd;
    if (rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16)
      cd_rot = {cd[27], cd[0:26], cd[55], cd[28:54]};
    else if (rnd != 5'd1)
      cd_rot = {cd[26:27], cd[0:25], cd[54:55], cd[28:53]};
    subkey = pc2(cd_rot);
    f      = pperm(sbox_layer(expand(r) ^ subkey));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l         <= '0;
      r         <= '0;
      cd        <= '0;
      rnd       <= '0;
      decrypted <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          {l, r} <= perm64(cipherText, 1'b0);
          cd     <= pc1(key);
          rnd    <= 5'd1;
        end
        ROUND: begin
          l   <= r;
          r   <= l ^ f;
          cd  <= cd_rot;
          rnd <= rnd + 5'd1;
          if (rnd == 5'(ROUNDS)) decrypted <= perm64({l ^ f, r}, 1'b1);
        end
        default: ;
      endcase
    end
  end

`ifdef DES_DECRYPT_PARITY_CHECK_EN
  function automatic logic parity_bad(input logic [0:63] k);
    parity_bad = 1'b0;
    for (int b = 0; b < 8; b++)
      if (!(^k[8*b +: 8])) parity_bad = 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)                              key_parity_err <= 1'b0;
    else if (state == IDLE && in_valid)   key_parity_err <= parity_bad(key);
    else if (state == DONE && out_ready)  key_parity_err <= 1'b0;
  end
`else
  // Parity bits are dropped by PC1 and never inspected in this build.
`endif

endmodule

// File: tb/tb_des_decrypt_iter.sv
// tb/tb_des_decrypt_iter.sv - scoreboard bench for des_decrypt_iter
// Parity flag checks are active when DES_DECRYPT_PARITY_CHECK_EN is defined.
module tb_des_decrypt_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [0:63] cipherText = '0;
  logic [0:63] key = '0;
  logic [0:63] decrypted;
`ifdef DES_DECRYPT_PARITY_CHECK_EN
  logic        key_parity_err;
`endif

  logic [0:63] sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int n;

  localparam int NV = 6;
  logic [0:63] vk  [NV] = '{64'h133457799BBCDFF1, 64'h0E329232EA6D0D73, 64'h0000000000000000,
                            64'hFFFFFFFFFFFFFFFF, 64'h133457799BBCDFF0, 64'h0101010101010101};
  logic [0:63] vct [NV] = '{64'h85E813540F0AB405, 64'h0000000000000000, 64'h8CA64DE9C1B123A7,
                            64'h7359B2163E4EDC58, 64'h85E813540F0AB405, 64'h8CA64DE9C1B123A7};
  logic [0:63] vpt [NV] = '{64'h0123456789ABCDEF, 64'h8787878787878787, 64'h0000000000000000,
                            64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF, 64'h0000000000000000};
`ifdef DES_DECRYPT_PARITY_CHECK_EN
  logic        vpar[NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif

  always #5 clk = ~clk;

  des_decrypt_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cipherText(cipherText), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .decrypted(decrypted)
`ifdef DES_DECRYPT_PARITY_CHECK_EN
    , .key_parity_err(key_parity_err)
`endif
  );

  task automatic check(input string tag, input logic [0:63] got, input logic [0:63] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
      else                check("decrypted", decrypted, sb.pop_front());
    end
  end

  task automatic send(input logic [0:63] ct, input logic [0:63] k, input logic [0:63] exp);
    int w = 0;
    cipherText = ct;
    key        = k;
    in_valid   = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    sb.push_back(exp);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      @(posedge clk);
      #1 cnt++;
    end
    check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_decrypted", decrypted, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency counted from the accepting edge (edge 1) to the edge raising out_valid.
    send(vct[0], vk[0], vpt[0]);
    wait_valid(n);
    check("latency", 64'(n + 1), 64'd17);
    @(posedge clk);
    #1 check("idle_after_hs", 64'(in_ready), 64'd1);
    check("valid_after_hs", 64'(out_valid), 64'd0);

    for (int i = 0; i < NV; i++) begin
      send(vct[i], vk[i], vpt[i]);
      wait_valid(n);
`ifdef DES_DECRYPT_PARITY_CHECK_EN
      check("parity_err", 64'(key_parity_err), 64'(vpar[i]));
`endif
      @(posedge clk);
      #1 check("vec_idle", 64'(in_ready), 64'd1);
`ifdef DES_DECRYPT_PARITY_CHECK_EN
      check("parity_clr", 64'(key_parity_err), 64'd0);
`endif
    end

    // Back-pressure with a competing input held valid.
    out_ready = 1'b0;
    send(vct[0], vk[0], vpt[0]);
    wait_valid(n);
    cipherText = vct[1];
    key        = vk[1];
    in_valid   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold", decrypted, vpt[0]);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_ready_after_hs", 64'(in_ready), 64'd1);
    check("bp_valid_after_hs", 64'(out_valid), 64'd0);
    @(posedge clk);
    sb.push_back(vpt[1]);
    #1 in_valid = 1'b0;
    check("bp_second_accepted", 64'(in_ready), 64'd0);
    wait_valid(n);
    @(posedge clk);
    #1;

    // Reset 8 cycles after accept aborts the block.
    send(vct[0], vk[0], vpt[0]);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_decrypted", decrypted, 64'd0);
    send(vct[0], vk[0], vpt[0]);
    wait_valid(n);
    @(posedge clk);
    #1;

    // Inputs scrambled every cycle while rounds run.
    send(vct[1], vk[1], vpt[1]);
    for (int c = 0; c < 15; c++) begin
      cipherText = {$urandom, $urandom};
      key        = {$urandom, $urandom};
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_valid(n);
    @(posedge clk);
    #1;

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/des_decrypt_iter.md
Name: des_decrypt_iter

Overview:
- Iterative DES decryption core. It is the receive-side counterpart to the team's combinational DES encryption block.
- Takes one 64-bit ciphertext block and one 64-bit key through a valid/ready handshake, then runs one Feistel round per clock for 16 clocks.
- Delivers the plaintext through a valid/ready output handshake.
- Sits between the link receive buffer and the plaintext consumer.

Parameters:
- ROUNDS, 16, number of Feistel rounds. Fixed at 16 for DES compliance; any other value is unsupported.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  cipherText/key valid
- in_ready  output  1  block can accept a new input
- cipherText  input  [0:63]  ciphertext; bit 0 = DES bit 1 (MSB)
- key  input  [0:63]  64-bit DES key including parity bits; bit 0 = DES bit 1
- out_valid  output  1  decrypted is valid
- out_ready  input  1  consumer accepts decrypted
- decrypted  output  [0:63]  plaintext; bit 0 = DES bit 1

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, decrypted=0, round counter=0, state=IDLE.
- Constants: IP, FP, E, P, PC1, PC2 and S1..S8 are hardwired FIPS 46-3 tables. No file loading.
- FSM state IDLE:
  - in_ready=1.
  - A transfer occurs on an edge where in_valid&&in_ready.
  - On that edge: L/R <= IP(cipherText), CD <= PC1(key) (56 bits), rnd <= 1, state -> ROUND.
  - The key is captured only at this point; later key changes have no effect.
- FSM state ROUND (in_ready=0), for rnd = 1..16:
  - CD' = CD rotated right, each 28-bit half independently:
    - by 0 when rnd=1;
    - by 1 when rnd is 2, 9 or 16;
    - by 2 otherwise.
  - Subkey = PC2(CD'). This yields K16 first and K1 last.
  - f = P(S(E(R) xor subkey)). S-box row = {b0,b5}, column = b1..b4.
  - L <= R; R <= L xor f; CD <= CD'; rnd <= rnd+1.
  - After rnd=16 completes: decrypted <= FP({R,L}) (halves swapped), out_valid <= 1, state -> DONE.
- FSM state DONE:
  - out_valid=1; decrypted is held stable.
  - On out_valid&&out_ready: out_valid <= 0, state -> IDLE, in_ready=1 on the next cycle.
- Latency: out_valid rises 17 edges after the accepting edge (1 load + 16 rounds). Throughput is 1 block per 18 cycles when out_ready is tied high.
- Back-pressure: with out_ready=0, DONE is held indefinitely. in_ready stays 0 and no new input is accepted (no overwrite).
- in_valid asserted during ROUND/DONE is ignored. The source must hold its data per valid/ready rules.
- Reset asserted in any state aborts the operation on that edge and forces the reset values. No partial result is ever presented.
- Parity bits (key bits 7,15,...,63) do not affect the result.

Optional Feature:
- Macro: DES_DECRYPT_PARITY_CHECK_EN
- With the macro defined:
  - Adds output key_parity_err (1 bit), reset 0.
  - On the accepting edge, each of the 8 key bytes is checked for odd parity. key_parity_err is registered high if any byte has even parity.
  - key_parity_err is held with out_valid and cleared when the output handshake completes.
  - Decryption proceeds and its result is unaffected.
- Without the macro: the port is absent and parity is not checked.

Test Plan:
- key=133457799BBCDFF1, cipherText=85E813540F0AB405, out_ready=1 -> out_valid rises 17 cycles after accept; decrypted=0123456789ABCDEF.
- key=0E329232EA6D0D73, cipherText=0000000000000000 -> decrypted=8787878787878787.
- Back-pressure: first vector with out_ready=0 for 10 cycles after out_valid; drive a second in_valid meanwhile -> decrypted stays 0123456789ABCDEF, in_ready=0, second input not accepted until one cycle after the out handshake.
- Reset mid-operation: assert rst 8 cycles after accept -> next cycle out_valid=0, in_ready=1, decrypted=0; a fresh accept of the first vector again gives 0123456789ABCDEF.
- Input stability: change key and cipherText every cycle during ROUND -> result still matches the values captured at accept.
- (DES_DECRYPT_PARITY_CHECK_EN) key=133457799BBCDFF0, cipherText=85E813540F0AB405 -> key_parity_err=1 with out_valid, decrypted=0123456789ABCDEF; key=133457799BBCDFF1 -> key_parity_err=0.
